// File: rtl/row_col_mem_sequencer.sv
// row_col_mem_sequencer: load/stream controller for one single-port
// row_col_memory (1-cycle registered read). Loads MATRIX_SIZE rows from a
// valid/ready input stream, then replays them row by row for a programmable
// number of passes on a valid/ready output stream.
//
// Optional build macro ROW_COL_SEQ_STALL_CNT_EN adds a saturating stall
// counter (stall_count) with a synchronous clear (stall_clear).
module row_col_mem_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_COL_SIZE = 16,
    parameter int MATRIX_SIZE  = 16,
    parameter int ADDR_BITS    = $clog2(MATRIX_SIZE),
    parameter int PASS_BITS    = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic [PASS_BITS-1:0]               num_passes,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ROW_COL_SIZE*DATA_WIDTH-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ROW_COL_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_BITS-1:0]               out_row,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done,
`ifdef ROW_COL_SEQ_STALL_CNT_EN
    input  logic                               stall_clear,
    output logic [31:0]                        stall_count,
`endif
    output logic [ADDR_BITS-1:0]               mem_address,
    output logic                               mem_write_enable,
    output logic [ROW_COL_SIZE*DATA_WIDTH-1:0] mem_datain,
    input  logic [ROW_COL_SIZE*DATA_WIDTH-1:0] mem_dataout
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] PRIME  = 2'd2;
    localparam logic [1:0] STREAM = 2'd3;

    localparam logic [ADDR_BITS-1:0] LAST_ROW = ADDR_BITS'(MATRIX_SIZE - 1);

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;     // row currently presented on out_data
    logic [PASS_BITS-1:0] pass_cnt;
    logic [PASS_BITS-1:0] passes_q;
    logic                 in_hs;
    logic                 out_hs;

    assign in_ready         = (state == LOAD);
    assign out_valid        = (state == STREAM);
    assign busy             = (state != IDLE);
    assign in_hs            = in_ready & in_valid;
    assign out_hs           = out_valid & out_ready;
    assign mem_write_enable = in_hs;
    assign mem_datain       = in_data;
    assign out_data         = mem_dataout;
    assign out_row          = rd_ptr;
    assign out_last         = out_valid && (pass_cnt == passes_q - PASS_BITS'(1))
                              && (rd_ptr == LAST_ROW);

    // Memory address: write pointer while loading, otherwise the read look-ahead.
    // The memory read is registered, so on an accepted row the address already
    // points at the next row; the following cycle's mem_dataout then matches
    // rd_ptr. Without a handshake the address is held and out_data stays stable.
    always_comb begin
        // NOTE: default assignment first so no path leaves mem_address unassigned (no latch).
        mem_address = rd_ptr;
        if (state == LOAD) begin
            mem_address = wr_ptr;
        end else if (out_hs) begin
            mem_address = rd_ptr + ADDR_BITS'(1);
        end
    end

    // Control FSM, load/read pointers, pass counting and the done pulse.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
            passes_q <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        pass_cnt <= '0;
                        passes_q <= (num_passes == '0) ? PASS_BITS'(1) : num_passes;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        wr_ptr <= wr_ptr + ADDR_BITS'(1);
                        if (wr_ptr == LAST_ROW) begin
                            state <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    // Row 0 is being read; it appears on mem_dataout next cycle.
                    state <= STREAM;
                end
                STREAM: begin
                    if (out_hs) begin
                        // Natural ADDR_BITS overflow wraps the last row back to 0.
                        rd_ptr <= rd_ptr + ADDR_BITS'(1);
                        if (rd_ptr == LAST_ROW) begin
                            pass_cnt <= pass_cnt + PASS_BITS'(1);
                        end
                        if (out_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROW_COL_SEQ_STALL_CNT_EN
    logic stall_evt;

    // A stall is a presented row not taken, or a load cycle without input data.
    assign stall_evt = (out_valid & ~out_ready) | (in_ready & ~in_valid);

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_count <= '0;
        end else if (stall_clear) begin
            stall_count <= '0;
        end else if (stall_evt && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/row_col_mem_sequencer.md
Name: row_col_mem_sequencer

Overview:
Load/stream controller that owns one single-access row_col_memory instance (read latency 1 cycle, registered dataout). It accepts MATRIX_SIZE rows on a valid/ready input stream and writes them to consecutive addresses. It then replays the stored matrix row by row, for a programmable number of passes, on a valid/ready output stream feeding the matrix_multiply datapath. Sits between the matrix source (host/DMA) and the multiplier's row/column operand port.

Parameters:
DATA_WIDTH, 16, bits per matrix element
ROW_COL_SIZE, 16, elements per row/column word
MATRIX_SIZE, 16, rows stored (memory depth)
ADDR_BITS, $clog2(MATRIX_SIZE), memory address width
PASS_BITS, 8, width of pass-count input

Ports:
clk  input  1  clock; all logic rising-edge
resetn  input  1  asynchronous active-low reset
start  input  1  begin load when IDLE; ignored otherwise
num_passes  input  PASS_BITS  replay count, sampled on accepted start; 0 treated as 1
in_valid  input  1  input row valid
in_ready  output  1  input row accepted when in_valid & in_ready
in_data  input  ROW_COL_SIZE*DATA_WIDTH  input row
out_valid  output  1  output row valid
out_ready  input  1  downstream accepts row
out_data  output  ROW_COL_SIZE*DATA_WIDTH  output row; wired directly from mem_dataout
out_row  output  ADDR_BITS  row index of out_data
out_last  output  1  last row of last pass
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the final row is accepted
mem_address  output  ADDR_BITS  to memory address
mem_write_enable  output  1  to memory write_enable
mem_datain  output  ROW_COL_SIZE*DATA_WIDTH  to memory datain; wired to in_data
mem_dataout  input  ROW_COL_SIZE*DATA_WIDTH  from memory dataout

Behaviour:
- Reset (async, resetn=0): state IDLE, all counters 0. in_ready=0, out_valid=0, out_last=0, out_row=0, busy=0, done=0, mem_address=0, mem_write_enable=0. Memory contents are not cleared.
- States:
  - IDLE: start=1 -> LOAD; wr_ptr=0; pass_cnt=0; passes_q=max(num_passes,1).
  - LOAD: in_ready=1. mem_write_enable = in_valid (combinational); mem_address = wr_ptr.
    - Each handshake writes in_data at wr_ptr and increments wr_ptr.
    - Handshake with wr_ptr==MATRIX_SIZE-1 -> PRIME; mem_address=0 registered for the next cycle.
  - PRIME: exactly one cycle with mem_address=0 and no outputs valid -> STREAM.
  - STREAM: out_valid=1; out_row = current mem_address; out_data = mem_dataout.
    - On out_valid & out_ready, mem_address advances, wrapping MATRIX_SIZE-1 -> 0. Each wrap increments pass_cnt.
    - mem_address is held while out_ready=0, so out_data stays stable under backpressure.
    - Throughput is one row per cycle.
    - out_last = (pass_cnt==passes_q-1) & (mem_address==MATRIX_SIZE-1).
    - Handshake with out_last=1 -> IDLE, and done=1 for one cycle.
- Latency: the first output row is valid 2 cycles after the final load handshake (PRIME, then STREAM).
- in_ready=0 in all states except LOAD. in_valid is ignored outside LOAD.
- mem_write_enable is never asserted outside LOAD.
- start while busy=1 is ignored. start in the same cycle as done is taken, since the state is already IDLE.
- Reset mid-operation aborts immediately to IDLE. No done pulse is generated.
- pass_cnt is PASS_BITS wide; passes_q=255 must complete 255 passes with no overflow.
- MATRIX_SIZE must be a power of two ≥2; wrap logic relies on natural ADDR_BITS overflow.

Optional Feature:
ROW_COL_SEQ_STALL_CNT_EN
- Defined: adds output stall_count (32 bits) and input stall_clear (1 bit).
  - stall_count increments each cycle out_valid=1 & out_ready=0, and also each cycle in LOAD with in_valid=0. It saturates at 0xFFFFFFFF.
  - stall_clear=1 zeroes it synchronously and has priority over increment.
  - Async reset clears it to 0.
- Undefined: neither port exists; no counter logic is generated.

Test Plan:
- Use MATRIX_SIZE=4 for all cases.
- Basic load/replay: start with num_passes=1, then load rows 0xA..0xD back-to-back with out_ready=1. Expect mem writes at addresses 0-3, first out_valid 2 cycles after the last load handshake, and out_data rows A,B,C,D with out_row 0-3. out_last is high on D only, then done pulses once and busy drops.
- Multi-pass with num_passes=0 then 3: num_passes=0 yields exactly 4 output rows. num_passes=3 yields 12 rows in sequence A,B,C,D repeated; out_last is high only on the 12th.
- Backpressure: deassert out_ready for 5 cycles while row B is presented. out_data=B and out_row=1 stay stable, mem_address is held, and there are no lost or duplicated rows.
- Input gaps and ignored traffic: in_valid toggled 1-0-1 during load gives exactly 4 writes. in_valid=1 while IDLE gives in_ready=0 and no write. start pulsed during STREAM does not disturb the sequence.
- Reset mid-stream: assert resetn=0 after row B is output. All outputs return to reset values immediately with no done pulse. A new start loads and replays correctly.
- With ROW_COL_SEQ_STALL_CNT_EN: 5 backpressure cycles plus 2 load gaps give stall_count=7. stall_clear then returns it to 0.
